// File: rtl/game_ctrl_pkg.sv
// Shared game-control constants: ghost/flag bit positions, score units, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package game_ctrl_pkg;

  // Bit positions inside the 6-bit collision flag vector
  localparam int RG_IDX    = 0;
  localparam int PG_IDX    = 1;
  localparam int CG_IDX    = 2;
  localparam int OG_IDX    = 3;
  localparam int PDOT_IDX  = 4;
  localparam int EDOT_IDX  = 5;
  localparam int NUM_FLAGS = 6;

  // Score is carried in units of 10 points; 306 is the largest single-frame total
  localparam int SCORE_W = 10;
  localparam logic [SCORE_W-1:0] EDOT_PTS       = 10'd1;
  localparam logic [SCORE_W-1:0] PDOT_PTS       = 10'd5;
  localparam logic [SCORE_W-1:0] GHOST_BASE_PTS = 10'd20;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    DEATH     = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

endpackage

// File: rtl/collision_frame_latch.sv
// Sticky per-frame collision latch: accumulates pixel-rate flags, restarts at startOfFrame.
// Latency: a flag is visible on frame_flags the cycle after it is seen; frame_flags is the frame's snapshot on the startOfFrame cycle.
// Backpressure: none; the consumer samples frame_flags on startOfFrame.
// Ports: clk, resetN (async active-low), startOfFrame, col[5:0] raw flags, frame_flags[5:0] accumulated flags.
module collision_frame_latch
  import game_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_FLAGS-1:0] col,
  output logic [NUM_FLAGS-1:0] frame_flags
);

  logic [NUM_FLAGS-1:0] sticky_q;

  // A flag seen on the startOfFrame cycle seeds the new frame instead of
  // being OR-ed into the frame that is being handed over.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sticky_q <= '0;
    end else if (startOfFrame) begin
      sticky_q <= col;
    end else begin
      sticky_q <= sticky_q | col;
    end
  end

  assign frame_flags = sticky_q;

endmodule

// File: rtl/collision_handler.sv
// Resolves one frame of Pac-Man collisions into score/ghost/death events, frightened mode and lives.
// Latency: all outputs change 1 cycle after startOfFrame (new_game in GAME_OVER takes effect the next cycle).
// Backpressure: none; events are single-cycle pulses that consumers must take.
// Ports: clk, resetN, startOfFrame, new_game, pm_*_col flags in; score_add/score_valid, ghost_eaten,
//        dot_eaten, pm_death, level_restart pulses; frightened, freeze, lives, game_over levels out.
module collision_handler
  import game_ctrl_pkg::*;
#(
  parameter int FRIGHT_FRAMES = 360,
  parameter int DEATH_FRAMES  = 120,
  parameter int START_LIVES   = 3,
  parameter int LIVES_W       = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               new_game,
  input  logic               pm_rg_col,
  input  logic               pm_pg_col,
  input  logic               pm_cg_col,
  input  logic               pm_og_col,
  input  logic               pm_pdot_col,
  input  logic               pm_edot_col,
  output logic [SCORE_W-1:0] score_add,
  output logic               score_valid,
  output logic [3:0]         ghost_eaten,
  output logic               dot_eaten,
  output logic               frightened,
  output logic               pm_death,
  output logic               freeze,
  output logic               level_restart,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int TMR_W  = $clog2(FRIGHT_FRAMES + 1);
  localparam int DCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [TMR_W-1:0]   FRIGHT_LOAD = TMR_W'(FRIGHT_FRAMES);
  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [DCNT_W-1:0]  DEATH_LAST  = DCNT_W'(DEATH_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);

  logic [NUM_FLAGS-1:0] col;
  logic [NUM_FLAGS-1:0] frame_flags;

  assign col = {pm_edot_col, pm_pdot_col, pm_og_col, pm_cg_col, pm_pg_col, pm_rg_col};

  collision_frame_latch u_latch (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .col          (col),
    .frame_flags  (frame_flags)
  );

  game_state_t        state_q,  state_d;
  logic [LIVES_W-1:0] lives_q,  lives_d;
  logic               fright_q, fright_d;
  logic [TMR_W-1:0]   tmr_q,    tmr_d;
  logic [1:0]         chain_q,  chain_d;
  logic [3:0]         eaten_q,  eaten_d;
  logic [DCNT_W-1:0]  dcnt_q,   dcnt_d;

  logic [SCORE_W-1:0] score_d;
  logic [3:0]         ghost_eaten_d;
  logic               dot_eaten_d, pm_death_d, level_restart_d;
  logic [3:0]         live_hits;
  logic               pdot_hit, edot_hit;

  // Eyes (already-eaten ghosts) never collide until frightened mode ends.
  assign live_hits = frame_flags[OG_IDX:RG_IDX] & ~eaten_q;
  assign pdot_hit  = frame_flags[PDOT_IDX];
  assign edot_hit  = frame_flags[EDOT_IDX];

  always_comb begin
    state_d         = state_q;
    lives_d         = lives_q;
    fright_d        = fright_q;
    tmr_d           = tmr_q;
    chain_d         = chain_q;
    eaten_d         = eaten_q;
    dcnt_d          = dcnt_q;
    score_d         = '0;
    ghost_eaten_d   = '0;
    dot_eaten_d     = 1'b0;
    pm_death_d      = 1'b0;
    level_restart_d = 1'b0;

    if (new_game && state_q == GAME_OVER) begin
      state_d  = PLAY;
      lives_d  = LIVES_INIT;
      fright_d = 1'b0;
      tmr_d    = '0;
      chain_d  = '0;
      eaten_d  = '0;
      dcnt_d   = '0;
    end else if (startOfFrame) begin
      case (state_q)
        PLAY: begin
          if (!fright_q && (|live_hits)) begin
            // Death swallows every other event of the frame.
            pm_death_d = 1'b1;
            lives_d    = lives_q - 1'b1;
            fright_d   = 1'b0;
            tmr_d      = '0;
            chain_d    = '0;
            eaten_d    = '0;
            dcnt_d     = '0;
            state_d    = DEATH;
          end else begin
            // Ghosts are scored before the frame's power dot can reset the chain.
            if (fright_q) begin
              for (int i = RG_IDX; i <= OG_IDX; i++) begin
                if (live_hits[i]) begin
                  ghost_eaten_d[i] = 1'b1;
                  eaten_d[i]       = 1'b1;
                  score_d          = score_d + (GHOST_BASE_PTS << chain_d);
                  if (chain_d != 2'd3) chain_d = chain_d + 2'd1;
                end
              end
            end
            if (tmr_q != '0) begin
              tmr_d = tmr_q - 1'b1;
              if (tmr_q == TMR_ONE) begin
                fright_d = 1'b0;
                chain_d  = '0;
                eaten_d  = '0;
              end
            end
            if (pdot_hit) begin
              score_d  = score_d + PDOT_PTS;
              tmr_d    = FRIGHT_LOAD;
              fright_d = 1'b1;
              chain_d  = '0;
              eaten_d  = '0;
            end
            if (edot_hit) score_d = score_d + EDOT_PTS;
            dot_eaten_d = pdot_hit | edot_hit;
          end
        end
        DEATH: begin
          if (dcnt_q == DEATH_LAST) begin
            if (lives_q != '0) begin
              state_d         = PLAY;
              level_restart_d = 1'b1;
            end else begin
              state_d = GAME_OVER;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= PLAY;
      lives_q       <= LIVES_INIT;
      fright_q      <= 1'b0;
      tmr_q         <= '0;
      chain_q       <= '0;
      eaten_q       <= '0;
      dcnt_q        <= '0;
      score_add     <= '0;
      score_valid   <= 1'b0;
      ghost_eaten   <= '0;
      dot_eaten     <= 1'b0;
      pm_death      <= 1'b0;
      level_restart <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      fright_q      <= fright_d;
      tmr_q         <= tmr_d;
      chain_q       <= chain_d;
      eaten_q       <= eaten_d;
      dcnt_q        <= dcnt_d;
      score_add     <= score_d;
      score_valid   <= (score_d != '0);
      ghost_eaten   <= ghost_eaten_d;
      dot_eaten     <= dot_eaten_d;
      pm_death      <= pm_death_d;
      level_restart <= level_restart_d;
    end
  end

  assign frightened = fright_q;
  assign lives      = lives_q;
  assign freeze     = (state_q != PLAY);
  assign game_over  = (state_q == GAME_OVER);

endmodule

// File: tb/tb_collision_handler.sv
// Bench for collision_handler: directed frame scenarios plus random frames against a frame-level model.
// Latency: outputs checked every cycle, #1 after the rising edge.
// Backpressure: n/a.
module tb_collision_handler;

  localparam int FRIGHT = 360;
  localparam int DEATHF = 120;
  localparam int LIVES0 = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, new_game = 1'b0;
  logic rg = 1'b0, pg = 1'b0, cg = 1'b0, og = 1'b0, pdot = 1'b0, edot = 1'b0;
  logic [9:0] score_add;
  logic       score_valid, dot_eaten, frightened, pm_death, freeze, level_restart, game_over;
  logic [3:0] ghost_eaten;
  logic [1:0] lives;

  collision_handler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .new_game(new_game),
    .pm_rg_col(rg), .pm_pg_col(pg), .pm_cg_col(cg), .pm_og_col(og),
    .pm_pdot_col(pdot), .pm_edot_col(edot),
    .score_add(score_add), .score_valid(score_valid), .ghost_eaten(ghost_eaten),
    .dot_eaten(dot_eaten), .frightened(frightened), .pm_death(pm_death),
    .freeze(freeze), .level_restart(level_restart), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: mode 0=play 1=dead 2=game over
  int         m_mode, m_lives, m_fr, m_chain, m_dl;
  logic [3:0] m_eaten;
  logic [5:0] pending;
  int         e_score;
  logic [3:0] e_ge;
  logic       e_dot, e_death, e_lr;

  // Last observed event outputs after a startOfFrame / new_game cycle
  int         o_score;
  logic [3:0] o_ge;
  logic       o_valid, o_dot, o_death, o_lr, o_fr, o_freeze, o_go;
  int         o_lives;

  localparam logic [5:0] F_RG = 6'b000001, F_PG = 6'b000010, F_CG = 6'b000100,
                         F_OG = 6'b001000, F_PD = 6'b010000, F_ED = 6'b100000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lives = LIVES0; m_fr = 0; m_chain = 0; m_dl = 0; m_eaten = '0;
    e_score = 0; e_ge = '0; e_dot = 0; e_death = 0; e_lr = 0;
  endtask

  task automatic resolve(input logic [5:0] f);
    int pts;
    logic [3:0] hit;
    pts = 0;
    if (m_mode == 0) begin
      hit = f[3:0] & ~m_eaten;
      if (m_fr == 0 && hit != 4'd0) begin
        e_death = 1; m_lives = m_lives - 1; m_chain = 0; m_eaten = '0;
        m_mode = 1; m_dl = DEATHF;
      end else begin
        if (m_fr > 0) begin
          for (int g = 0; g < 4; g++) begin
            if (hit[g]) begin
              e_ge[g] = 1'b1; m_eaten[g] = 1'b1;
              pts = pts + 20 * (1 << m_chain);
              if (m_chain < 3) m_chain = m_chain + 1;
            end
          end
          m_fr = m_fr - 1;
          if (m_fr == 0) begin m_chain = 0; m_eaten = '0; end
        end
        if (f[4]) begin pts = pts + 5; m_fr = FRIGHT; m_chain = 0; m_eaten = '0; end
        if (f[5]) pts = pts + 1;
        e_dot = f[4] | f[5];
        e_score = pts;
      end
    end else if (m_mode == 1) begin
      m_dl = m_dl - 1;
      if (m_dl == 0) begin
        if (m_lives > 0) begin m_mode = 0; e_lr = 1; end
        else m_mode = 2;
      end
    end
  endtask

  task automatic check_all();
    check("score_add",     16'(score_add),     16'(e_score));
    check("score_valid",   16'(score_valid),   16'(e_score != 0));
    check("ghost_eaten",   16'(ghost_eaten),   16'(e_ge));
    check("dot_eaten",     16'(dot_eaten),     16'(e_dot));
    check("pm_death",      16'(pm_death),      16'(e_death));
    check("level_restart", 16'(level_restart), 16'(e_lr));
    check("frightened",    16'(frightened),    16'(m_fr > 0));
    check("freeze",        16'(freeze),        16'(m_mode != 0));
    check("game_over",     16'(game_over),     16'(m_mode == 2));
    check("lives",         16'(lives),         16'(m_lives));
  endtask

  task automatic cyc(input logic [5:0] f, input bit sof, input bit ng);
    @(negedge clk);
    {edot, pdot, og, cg, pg, rg} = f;
    startOfFrame = sof;
    new_game = ng;
    e_score = 0; e_ge = '0; e_dot = 0; e_death = 0; e_lr = 0;
    if (ng && m_mode == 2) begin
      m_mode = 0; m_lives = LIVES0; m_fr = 0; m_chain = 0; m_eaten = '0; m_dl = 0;
    end else if (sof) begin
      resolve(pending);
    end
    if (sof) pending = f;
    else pending = pending | f;
    @(posedge clk);
    #1;
    check_all();
    if (sof || ng) begin
      o_score = int'(score_add); o_valid = score_valid; o_ge = ghost_eaten; o_dot = dot_eaten;
      o_death = pm_death; o_lr = level_restart; o_fr = frightened; o_freeze = freeze;
      o_go = game_over; o_lives = int'(lives);
    end
  endtask

  // len ordinary cycles, flags f held from cycle start for hold cycles, then a clean startOfFrame
  task automatic frame(input logic [5:0] f, input int len, input int start, input int hold);
    for (int i = 0; i < len; i++) cyc((i >= start && i < start + hold) ? f : 6'd0, 1'b0, 1'b0);
    cyc(6'd0, 1'b1, 1'b0);
  endtask

  task automatic qframe(input logic [5:0] f);
    frame(f, 4, 1, 2);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) qframe(6'(i * 7) & 6'b001111);
  endtask

  initial begin
    logic [5:0] rf;
    model_reset();
    pending = '0;
    #12;
    check_all();
    check("reset_lives", 16'(lives), 16'd3);
    @(negedge clk);
    resetN = 1'b1;

    // edot held 50 cycles
    frame(F_ED, 60, 5, 50);
    check("t1_score", 16'(o_score), 16'd1);
    check("t1_valid", 16'(o_valid), 16'd1);
    check("t1_dot",   16'(o_dot),   16'd1);

    // power dot then chained ghosts
    qframe(F_PD);
    check("t2_fright", 16'(o_fr), 16'd1);
    check("t2_pd_score", 16'(o_score), 16'd5);
    qframe(F_RG | F_PG);
    check("t2_ge", 16'(o_ge), 16'b0011);
    check("t2_score", 16'(o_score), 16'd60);
    qframe(F_CG);
    check("t2_cg_score", 16'(o_score), 16'd80);

    // frightened expiry then death
    qframe(F_PD);
    for (int i = 0; i < FRIGHT - 1; i++) qframe(6'd0);
    check("t3_fright_last", 16'(o_fr), 16'd1);
    qframe(6'd0);
    check("t3_fright_end", 16'(o_fr), 16'd0);
    qframe(F_RG);
    check("t3_death", 16'(o_death), 16'd1);
    check("t3_lives", 16'(o_lives), 16'd2);
    check("t3_freeze", 16'(o_freeze), 16'd1);

    // death sequence and game over
    idle_frames(DEATHF - 1);
    check("t4_still_frozen", 16'(o_freeze), 16'd1);
    qframe(F_ED);
    check("t4_restart", 16'(o_lr), 16'd1);
    check("t4_unfreeze", 16'(o_freeze), 16'd0);
    cyc(6'd0, 1'b0, 1'b1);
    check("t4_ng_ignored", 16'(o_lives), 16'd2);
    qframe(F_OG);
    idle_frames(DEATHF);
    qframe(F_CG);
    check("t4_lives0", 16'(o_lives), 16'd0);
    idle_frames(DEATHF);
    check("t4_game_over", 16'(o_go), 16'd1);
    check("t4_no_restart", 16'(o_lr), 16'd0);
    qframe(F_RG | F_ED);
    cyc(6'd0, 1'b0, 1'b1);
    check("t4_ng_lives", 16'(o_lives), 16'd3);
    check("t4_ng_play", 16'(o_go), 16'd0);

    // simultaneous death and dots
    qframe(F_OG | F_ED | F_PD);
    check("t5_death", 16'(o_death), 16'd1);
    check("t5_valid", 16'(o_valid), 16'd0);
    check("t5_dot", 16'(o_dot), 16'd0);
    check("t5_fright", 16'(o_fr), 16'd0);
    idle_frames(DEATHF);

    // flag on the startOfFrame cycle belongs to the next frame
    cyc(F_ED, 1'b1, 1'b0);
    check("t6_sof_now", 16'(o_valid), 16'd0);
    qframe(6'd0);
    check("t6_sof_next", 16'(o_score), 16'd1);

    // random frames
    for (int n = 0; n < 300; n++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) cyc(6'd0, 1'b0, 1'b1);
      rf = '0;
      for (int b = 0; b < 6; b++) rf[b] = ($urandom_range(0, 5) == 0);
      frame(rf, $urandom_range(2, 9), $urandom_range(0, 2), $urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) cyc(6'(1 << $urandom_range(0, 5)), 1'b1, 1'b0);
    end

    // steer to non-frightened play, die, then reset mid-death
    for (int n = 0; n < 600; n++) begin
      if (m_mode == 0 && m_fr == 0) break;
      if (m_mode == 2) cyc(6'd0, 1'b0, 1'b1);
      else qframe(6'd0);
    end
    check("t6_reach_play", 16'(m_mode == 0 && m_fr == 0), 16'd1);
    qframe(F_RG);
    check("t6_die", 16'(o_death), 16'd1);
    idle_frames(5);
    @(negedge clk);
    edot = 1'b1;
    #2 resetN = 1'b0;
    #1;
    model_reset();
    pending = '0;
    check_all();
    check("t6_rst_lives", 16'(lives), 16'd3);
    check("t6_rst_freeze", 16'(freeze), 16'd0);
    @(negedge clk);
    edot = 1'b0;
    resetN = 1'b1;
    qframe(6'd0);
    check("t6_rst_discard", 16'(o_valid), 16'd0);
    qframe(F_PD);
    check("t6_rst_pd", 16'(o_score), 16'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
